// File: rtl/spike_generator.sv
// Threshold-and-fire stage of a leaky integrate-and-fire neuron pipeline.
// It compares a decayed float32 potential against THRESHOLD, writes back the potential and queues a spike packet.
module spike_generator #(
  parameter logic [31:0] THRESHOLD = 32'h41F00000,
  parameter logic [31:0] V_RESET   = 32'h00000000,
  parameter int          REFRACT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_potential,
  input  logic [11:0] in_addr,
  output logic        pot_valid,
  output logic [31:0] out_potential,
  output logic        spike_valid,
  input  logic        spike_ready,
  output logic [11:0] spike_addr,
  output logic [15:0] spike_count,
  output logic [1:0]  fsm_state,
  output logic [3:0]  refract_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the sender holds its data stable while valid=1 and ready=0.

  localparam logic [3:0] REFRACT_V = REFRACT[3:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SPIKE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pot_q;
  logic [11:0] addr_q;
  logic        fire;

  // Ordered float compare a >= b; any operand with exponent 8'hFF yields 0.
  function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
    logic r;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) r = 1'b0;
    else if (a[30:0] == 31'd0 && b[30:0] == 31'd0) r = 1'b1;
    else if (!a[31] && !b[31]) r = (a[30:0] >= b[30:0]);
    else if (!a[31] && b[31]) r = 1'b1;
    else if (a[31] && !b[31]) r = 1'b0;
    else r = (a[30:0] <= b[30:0]);
    return r;
  endfunction

  assign fire      = (state == EVAL) && (refract_cnt == 4'd0) && fp_ge(pot_q, THRESHOLD);
  assign in_ready  = (state == IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = EVAL;
      EVAL:    state_next = fire ? SPIKE : IDLE;
      SPIKE:   if (spike_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pot_q         <= 32'd0;
      addr_q        <= 12'd0;
      pot_valid     <= 1'b0;
      out_potential <= 32'd0;
      spike_valid   <= 1'b0;
      spike_addr    <= 12'd0;
      spike_count   <= 16'd0;
      refract_cnt   <= 4'd0;
    end else begin
      pot_valid <= 1'b0;
      if (in_valid && in_ready) begin
        pot_q  <= in_potential;
        addr_q <= in_addr;
      end
      if (state == EVAL) begin
        pot_valid     <= 1'b1;
        // A refractory neuron is clamped to V_RESET even though it does not fire.
        out_potential <= (fire || refract_cnt != 4'd0) ? V_RESET : pot_q;
        if (fire) begin
          spike_valid <= 1'b1;
          spike_addr  <= addr_q;
        end
      end
      if (state == SPIKE && spike_ready) begin
        spike_valid <= 1'b0;
        if (spike_count != 16'hFFFF) spike_count <= spike_count + 16'd1;
      end
      // The load in the fire cycle takes priority over a coincident clear.
      if (fire) refract_cnt <= REFRACT_V;
      else if (clear && refract_cnt != 4'd0) refract_cnt <= refract_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_spike_generator.sv
// Self-checking bench for spike_generator: directed vectors plus randomized traffic
// checked against a real-valued threshold model with a refractory counter and spike tally.
module tb_spike_generator;

  localparam logic [31:0] THRESHOLD = 32'h41F00000;
  localparam logic [31:0] V_RESET   = 32'h00000000;
  localparam int          REFRACT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_potential = 32'd0;
  logic [11:0] in_addr = 12'd0;
  logic        pot_valid;
  logic [31:0] out_potential;
  logic        spike_valid;
  logic        spike_ready = 1'b0;
  logic [11:0] spike_addr;
  logic [15:0] spike_count;
  logic [1:0]  fsm_state;
  logic [3:0]  refract_cnt;

  int checks = 0;
  int errors = 0;
  int m_refr = 0;
  logic [15:0] m_count = 16'd0;
  logic [1:0]  idle_code = 2'd0;
  logic [31:0] specials [8] = '{32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h80000000,
                                32'h00000000, 32'h41F00000, 32'h41EFFFFF, 32'h00000001};

  spike_generator #(.THRESHOLD(THRESHOLD), .V_RESET(V_RESET), .REFRACT(REFRACT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_potential(in_potential), .in_addr(in_addr), .pot_valid(pot_valid),
    .out_potential(out_potential), .spike_valid(spike_valid), .spike_ready(spike_ready),
    .spike_addr(spike_addr), .spike_count(spike_count), .fsm_state(fsm_state),
    .refract_cnt(refract_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic real f32_to_real(input logic [31:0] b);
    real v;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) begin
      v = real'(b[22:0]);
      e = -149;
    end else begin
      v = 1.0 + real'(b[22:0]) / 8388608.0;
      e = e - 127;
    end
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    if (b[31]) v = -v;
    return v;
  endfunction

  function automatic bit model_fire(input logic [31:0] p);
    return (m_refr == 0) && (p[30:23] != 8'hFF) && (f32_to_real(p) >= f32_to_real(THRESHOLD));
  endfunction

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    if (m_refr > 0) m_refr--;
    @(negedge clk);
  endtask

  task automatic drain_refract();
    while (m_refr != 0) pulse_clear();
  endtask

  // One full transaction; starts and ends on a falling edge.
  task automatic do_txn(input logic [31:0] pot, input logic [11:0] addr,
                        input bit clear_eval, input int ready_delay, input string name);
    bit          exp_fire;
    logic [31:0] exp_out;
    int          n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready_wait got=%b want=1", name, in_ready); end
    exp_fire = model_fire(pot);
    exp_out  = (exp_fire || m_refr != 0) ? V_RESET : pot;
    in_valid = 1'b1; in_potential = pot; in_addr = addr;
    @(posedge clk);
    #1 in_valid = 1'b0; clear = clear_eval; in_potential = $urandom; in_addr = 12'($urandom);
    @(negedge clk);
    checks++;
    if (pot_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL %s eval_cycle pot_valid=%b in_ready=%b want 0 0", name, pot_valid, in_ready);
    end
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    checks++;
    if (pot_valid !== 1'b1 || out_potential !== exp_out) begin
      errors++; $display("FAIL %s writeback pot_valid=%b out=%h want 1 %h", name, pot_valid, out_potential, exp_out);
    end
    checks++;
    if (spike_valid !== exp_fire || in_ready !== !exp_fire || (exp_fire && spike_addr !== addr)) begin
      errors++; $display("FAIL %s spike spike_valid=%b addr=%0d in_ready=%b want %b %0d %b",
                         name, spike_valid, spike_addr, in_ready, exp_fire, addr, !exp_fire);
    end
    if (exp_fire) m_refr = REFRACT;
    else if (clear_eval && m_refr > 0) m_refr--;
    if (exp_fire) begin
      for (int i = 0; i < ready_delay; i++) begin
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (spike_valid !== 1'b1 || spike_addr !== addr || in_ready !== 1'b0 || pot_valid !== 1'b0 ||
            fsm_state === idle_code) begin
          errors++; $display("FAIL %s hold%0d spike_valid=%b addr=%0d in_ready=%b pot_valid=%b want 1 %0d 0 0",
                             name, i, spike_valid, spike_addr, in_ready, pot_valid, addr);
        end
      end
      spike_ready = 1'b1;
      @(posedge clk);
      #1 spike_ready = 1'b0;
      if (m_count != 16'hFFFF) m_count++;
    end
    @(negedge clk);
    checks++;
    if (spike_valid !== 1'b0 || in_ready !== 1'b1 || pot_valid !== 1'b0 || spike_count !== m_count) begin
      errors++; $display("FAIL %s after spike_valid=%b in_ready=%b pot_valid=%b count=%0d want 0 1 0 %0d",
                         name, spike_valid, in_ready, pot_valid, spike_count, m_count);
    end
    checks++;
    if (refract_cnt !== 4'(m_refr)) begin
      errors++; $display("FAIL %s refract_cnt got=%0d want=%0d", name, refract_cnt, m_refr);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (in_ready !== 1'b1 || pot_valid !== 1'b0 || spike_valid !== 1'b0 || out_potential !== 32'd0 ||
        spike_addr !== 12'd0 || spike_count !== 16'd0 || refract_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_state in_ready=%b pot_valid=%b spike_valid=%b out=%h addr=%0d count=%0d refr=%0d",
                         in_ready, pot_valid, spike_valid, out_potential, spike_addr, spike_count, refract_cnt);
    end
    idle_code = fsm_state;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_txn(32'h41DED852, 12'd5, 1'b0, 0, "below_thr");
    do_txn(32'h42000000, 12'd7, 1'b0, 0, "above_thr");
    drain_refract();
    do_txn(32'h41F00000, 12'd9, 1'b0, 1, "equal_thr");
    drain_refract();
    do_txn(32'hC2000000, 12'd10, 1'b0, 0, "negative");
    do_txn(32'h7FC00000, 12'd11, 1'b0, 0, "nan");
    do_txn(32'h7F800000, 12'd12, 1'b0, 0, "pos_inf");
    checks++;
    if (spike_count !== 16'd2) begin
      errors++; $display("FAIL directed_count got=%0d want=2", spike_count);
    end
  endtask

  task automatic test_backpressure();
    drain_refract();
    do_txn(32'h42480000, 12'd321, 1'b0, 5, "backpressure");
  endtask

  task automatic test_refractory();
    drain_refract();
    do_txn(32'h42000000, 12'd20, 1'b0, 0, "refr_fire");
    pulse_clear();
    do_txn(32'h42000000, 12'd21, 1'b0, 0, "refr_clamped");
    checks++;
    if (out_potential !== 32'd0 || spike_count !== m_count) begin
      errors++; $display("FAIL refr_clamped_direct out=%h count=%0d want 0 %0d", out_potential, spike_count, m_count);
    end
    pulse_clear();
    do_txn(32'h42000000, 12'd22, 1'b0, 0, "refr_refire");
  endtask

  task automatic test_clear_fire();
    drain_refract();
    do_txn(32'h42000000, 12'd30, 1'b1, 0, "clear_fire");
    checks++;
    if (refract_cnt !== 4'(REFRACT)) begin
      errors++; $display("FAIL clear_fire_load got=%0d want=%0d", refract_cnt, REFRACT);
    end
  endtask

  task automatic test_random();
    logic [31:0] p;
    for (int t = 0; t < 150; t++) begin
      for (int c = $urandom_range(0, 2); c > 0; c--) pulse_clear();
      case ($urandom_range(0, 5))
        0: p = $urandom;
        1: p = THRESHOLD + 32'($urandom_range(0, 40)) - 32'd20;
        2: p = specials[$urandom_range(0, 7)];
        3: p = {1'b0, 8'($urandom_range(128, 134)), 23'($urandom)};
        4: p = {1'b1, 31'($urandom)};
        default: p = {9'd0, 23'($urandom)};
      endcase
      do_txn(p, 12'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_spike();
    drain_refract();
    in_valid = 1'b1; in_potential = 32'h42000000; in_addr = 12'd44;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (spike_valid !== 1'b1) begin
      errors++; $display("FAIL rst_pre_spike spike_valid=%b want=1", spike_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    m_count = 16'd0; m_refr = 0;
    checks++;
    if (spike_valid !== 1'b0 || in_ready !== 1'b1 || spike_count !== 16'd0 || refract_cnt !== 4'd0 ||
        pot_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_spike spike_valid=%b in_ready=%b count=%0d refr=%0d want 0 1 0 0",
                         spike_valid, in_ready, spike_count, refract_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_potential = 32'h41DED852; in_addr = 12'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pot_valid !== 1'b1 || out_potential !== 32'h41DED852 || spike_valid !== 1'b0 || spike_count !== 16'd0) begin
      errors++; $display("FAIL rst_first_edge pot_valid=%b out=%h spike_valid=%b count=%0d want 1 41ded852 0 0",
                         pot_valid, out_potential, spike_valid, spike_count);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_refractory();
    test_clear_fire();
    test_random();
    test_reset_spike();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
